// File: rtl/insn_encoder_if.sv
// insn_encoder_if: request/response bundle between an opcode source, the
// insn_encoder FIFO and the instruction-memory writer.
//   master : opcode source / consumer side (drives requests, takes words)
//   slave  : the encoder itself
interface insn_encoder_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   opcode;
    logic          opcode_valid;
    logic          opcode_ready;
    logic [3:0]    insn;
    logic          insn_valid;
    logic          insn_ready;
    logic          flush;
    logic          error;
    logic [CW-1:0] count;

    modport master (
        output opcode, opcode_valid, insn_ready, flush,
        input  opcode_ready, insn, insn_valid, error, count
    );

    modport slave (
        input  opcode, opcode_valid, insn_ready, flush,
        output opcode_ready, insn, insn_valid, error, count
    );
endinterface

// File: rtl/insn_encoder.sv
// insn_encoder: converts one-hot 16-bit opcode requests into 4-bit
// instruction indices and queues them in a DEPTH-entry FIFO.
// Configuration macro: INSN_ENCODER_PRIORITY_EN
//   undefined (default) : only strictly one-hot requests are pushed; zero-hot
//                         and multi-hot requests are rejected with an error
//                         pulse.
//   defined             : multi-hot requests encode to their highest set bit
//                         and are pushed; only zero-hot is rejected.
module insn_encoder #(
    parameter int DEPTH = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    insn_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_error;

    logic          w_zero;
    logic          w_onehot;
    logic [3:0]    w_idx;
    logic          w_ready;
    logic          w_accept;
    logic          w_push;
    logic          w_reject;
    logic          w_pop;
    logic          w_nonempty;

    // Index of the highest set bit; for a one-hot word this is its only bit.
    function automatic logic [3:0] f_high_idx(input logic [15:0] op);
        logic [3:0] idx;
        idx = 4'd0;
        for (int b = 0; b < 16; b++) begin
            if (op[b]) begin
                idx = 4'(b);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Classify the request and derive the push/pop/reject strobes.
    always_comb begin
        w_zero     = (bus.opcode == 16'h0000);
        w_onehot   = ~w_zero & ((bus.opcode & (bus.opcode - 16'h0001)) == 16'h0000);
        w_idx      = f_high_idx(bus.opcode);
        w_nonempty = (r_count != {CW{1'b0}});
        // Ready depends only on registered occupancy and flush: no pass-through when full.
        w_ready    = (r_count != FULL_COUNT) & ~bus.flush;
        w_accept   = bus.opcode_valid & w_ready;
`ifdef INSN_ENCODER_PRIORITY_EN
        w_push     = w_accept & (w_onehot | ~w_zero);
`else
        w_push     = w_accept & w_onehot;
`endif
        w_reject   = w_accept & ~w_push;
        w_pop      = w_nonempty & bus.insn_ready & ~bus.flush;
    end

    assign bus.opcode_ready = w_ready;
    assign bus.insn_valid   = w_nonempty;
    assign bus.insn         = w_nonempty ? r_mem[r_rd_ptr] : 4'h0;
    assign bus.error        = r_error;
    assign bus.count        = r_count;

    // Pointer, occupancy and error-pulse registers; flush wins over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_error  <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_error  <= 1'b0;
        end else begin
            r_error <= w_reject;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset or flush.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_idx;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end
endmodule
